// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
//
// Shares one SRAM controller command port among N_REQ memory clients
// (library recording, resampling, library fetch). One pending client is
// picked in round-robin order and its command is latched. The command is
// held stable on the controller port across wait states. Completion is
// reported with a one-cycle o_ack pulse carrying the read data. An access
// that stalls longer than TIMEOUT wait cycles is aborted and flagged with
// o_err.
//
// Ports
//   i_clk             clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_req[N]          per-requester level request, held until its o_ack
//   i_wr[N]           per-requester write enable (1 = write)
//   i_addr[N*ADDR_W]  packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_wdata[N*DATA_W] packed write data, same packing
//   o_ack[N]          one-cycle completion pulse (one-hot or zero)
//   o_err             abort-by-timeout flag, valid with o_ack
//   o_rdata           read data, valid in the o_ack cycle
//   o_busy            arbiter not idle
//   o_grant_id        index of the current/last granted requester
//   core_mem_*        command port to the SRAM controller
//   core_mem_r_value  read data from the controller
//   core_wait         controller stall
// ---------------------------------------------------------------------------
module sram_access_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_wr,
  input  logic [N_REQ*ADDR_W-1:0]   i_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic                      o_err,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      core_mem_request,
  output logic                      core_mem_wr,
  output logic [ADDR_W-1:0]         core_mem_addr,
  output logic [DATA_W-1:0]         core_mem_w_value,
  input  logic [DATA_W-1:0]         core_mem_r_value,
  input  logic                      core_wait
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [GW-1:0]       r_last;
  logic [GW-1:0]       r_grant_id;
  logic [CW-1:0]       r_wait_cnt;
  logic [N_REQ-1:0]    r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy;
  logic                r_request;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [ADDR_W-1:0]   w_addr_arr  [N_REQ];
  logic [DATA_W-1:0]   w_wdata_arr [N_REQ];
  logic [GW:0]         w_sum       [N_REQ];
  logic [GW-1:0]       w_cand      [N_REQ];
  logic                w_any;
  logic [GW-1:0]       w_pick;

  // Unpack the per-requester commands and build the round-robin search
  // order: candidate gi is (last_grant + 1 + gi) mod N_REQ. The sum never
  // exceeds 2*N_REQ-1, so a single conditional subtract does the modulo.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign w_addr_arr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = i_wdata[gi*DATA_W +: DATA_W];
      assign w_sum[gi]       = {1'b0, r_last} + (GW+1)'(gi + 1);
      assign w_cand[gi]      = (w_sum[gi] >= (GW+1)'(N_REQ))
                               ? GW'(w_sum[gi] - (GW+1)'(N_REQ))
                               : GW'(w_sum[gi]);
    end
  endgenerate

  // Scan from the back so the earliest candidate in round-robin order wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) begin
        w_any  = 1'b1;
        w_pick = w_cand[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= GW'(N_REQ - 1);
      r_grant_id <= '0;
      r_wait_cnt <= '0;
      r_ack      <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_request  <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_BUSY;
            r_last     <= w_pick;
            r_grant_id <= w_pick;
            r_wait_cnt <= '0;
            r_busy     <= 1'b1;
            r_request  <= 1'b1;
            r_wr       <= i_wr[w_pick];
            r_addr     <= w_addr_arr[w_pick];
            r_wdata    <= w_wdata_arr[w_pick];
          end
        end

        ST_BUSY: begin
          if (!core_wait) begin
            r_state   <= ST_DONE;
            r_request <= 1'b0;
            r_ack     <= ONE_HOT0 << r_last;
            r_err     <= 1'b0;
            r_rdata   <= r_wr ? '0 : core_mem_r_value;
          end else if (r_wait_cnt == CW'(TIMEOUT)) begin
            // Controller never answered: give up so the other clients
            // are not starved, and tell the requester via o_err.
            r_state   <= ST_DONE;
            r_request <= 1'b0;
            r_ack     <= ONE_HOT0 << r_last;
            r_err     <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end

        ST_DONE: begin
          // One dead cycle lets the acknowledged client update or drop
          // its request before arbitration looks at i_req again.
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_ack     <= '0;
          r_err     <= 1'b0;
          r_busy    <= 1'b0;
          r_request <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack            = r_ack;
  assign o_err            = r_err;
  assign o_rdata          = r_rdata;
  assign o_busy           = r_busy;
  assign o_grant_id       = r_grant_id;
  assign core_mem_request = r_request;
  assign core_mem_wr      = r_wr;
  assign core_mem_addr    = r_addr;
  assign core_mem_w_value = r_wdata;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for sram_access_arbiter (N_REQ=3, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge; each
// tick() advances exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int N_REQ   = 3;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic                     i_clk;
  logic                     i_rst_n;
  logic [N_REQ-1:0]         i_req;
  logic [N_REQ-1:0]         i_wr;
  logic [N_REQ*ADDR_W-1:0]  i_addr;
  logic [N_REQ*DATA_W-1:0]  i_wdata;
  logic [N_REQ-1:0]         o_ack;
  logic                     o_err;
  logic [DATA_W-1:0]        o_rdata;
  logic                     o_busy;
  logic [1:0]               o_grant_id;
  logic                     core_mem_request;
  logic                     core_mem_wr;
  logic [ADDR_W-1:0]        core_mem_addr;
  logic [DATA_W-1:0]        core_mem_w_value;
  logic [DATA_W-1:0]        core_mem_r_value;
  logic                     core_wait;

  int n_assert = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_addr [N_REQ];

  sram_access_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req           (i_req),
    .i_wr            (i_wr),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .o_ack           (o_ack),
    .o_err           (o_err),
    .o_rdata         (o_rdata),
    .o_busy          (o_busy),
    .o_grant_id      (o_grant_id),
    .core_mem_request(core_mem_request),
    .core_mem_wr     (core_mem_wr),
    .core_mem_addr   (core_mem_addr),
    .core_mem_w_value(core_mem_w_value),
    .core_mem_r_value(core_mem_r_value),
    .core_wait       (core_wait)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n          = 1'b0;
    i_req            = '0;
    i_wr             = '0;
    i_addr           = '0;
    i_wdata          = '0;
    core_mem_r_value = '0;
    core_wait        = 1'b0;
    exp_addr[0]      = 20'h00100;
    exp_addr[1]      = 20'h00400;
    exp_addr[2]      = 20'h06800;
    for (int k = 0; k < N_REQ; k++) begin
      i_addr[k*ADDR_W +: ADDR_W] = exp_addr[k];
      i_wdata[k*DATA_W +: DATA_W] = DATA_W'(16'h1000 + k);
    end

    // ---- reset state ----
    tick(); tick();
    check("rst_ack",     32'(o_ack), 32'h0);
    check("rst_err",     32'(o_err), 32'h0);
    check("rst_busy",    32'(o_busy), 32'h0);
    check("rst_req",     32'(core_mem_request), 32'h0);
    check("rst_grant",   32'(o_grant_id), 32'h0);
    check("rst_addr",    32'(core_mem_addr), 32'h0);
    check("rst_rdata",   32'(o_rdata), 32'h0);
    $display("txn reset: outputs idle");

    // ---- fairness: all three requests held from reset ----
    i_rst_n          = 1'b1;
    i_req            = 3'b111;
    core_mem_r_value = 16'hA5A5;
    for (int n = 0; n < 6; n++) begin
      tick();
      check("fair_req",   32'(core_mem_request), 32'h1);
      check("fair_grant", 32'(o_grant_id), 32'(n % 3));
      check("fair_addr",  32'(core_mem_addr), 32'(exp_addr[n % 3]));
      check("fair_noack", 32'(o_ack), 32'h0);
      tick();
      check("fair_ack",   32'(o_ack), 32'(1 << (n % 3)));
      check("fair_rdata", 32'(o_rdata), 32'hA5A5);
      check("fair_reqlo", 32'(core_mem_request), 32'h0);
      if (n == 5) i_req = 3'b000;
      tick();
      check("fair_idle",  32'(o_busy), 32'h0);
      check("fair_ack0",  32'(o_ack), 32'h0);
      $display("txn fair %0d: grant=%0d ack=%b", n, n % 3, o_ack);
    end

    // ---- single read by requester 1, dropping i_req once granted ----
    i_req            = 3'b010;
    core_mem_r_value = 16'h1234;
    tick();
    check("rd_req",   32'(core_mem_request), 32'h1);
    check("rd_addr",  32'(core_mem_addr), 32'h00400);
    check("rd_wr",    32'(core_mem_wr), 32'h0);
    check("rd_grant", 32'(o_grant_id), 32'h1);
    i_req = 3'b000;
    tick();
    check("rd_reqlo", 32'(core_mem_request), 32'h0);
    check("rd_ack",   32'(o_ack), 32'b010);
    check("rd_rdata", 32'(o_rdata), 32'h1234);
    check("rd_err",   32'(o_err), 32'h0);
    tick();
    check("rd_ack0",  32'(o_ack), 32'h0);
    check("rd_hold",  32'(core_mem_addr), 32'h00400);
    $display("txn read req1 addr=00400 rdata=1234");

    // ---- write by requester 2 ----
    i_wr  = 3'b100;
    i_wdata[2*DATA_W +: DATA_W] = 16'hBEEF;
    i_req = 3'b100;
    tick();
    check("wr_req",   32'(core_mem_request), 32'h1);
    check("wr_wr",    32'(core_mem_wr), 32'h1);
    check("wr_addr",  32'(core_mem_addr), 32'h06800);
    check("wr_wval",  32'(core_mem_w_value), 32'hBEEF);
    i_req = 3'b000;
    tick();
    check("wr_ack",   32'(o_ack), 32'b100);
    check("wr_err",   32'(o_err), 32'h0);
    check("wr_rdata", 32'(o_rdata), 32'h0);
    i_wr = 3'b000;
    tick();
    check("wr_idle",  32'(o_busy), 32'h0);
    $display("txn write req2 addr=06800 wdata=BEEF");

    // ---- wait states: five stalled BUSY cycles on a read by requester 0 ----
    i_addr[0 +: ADDR_W] = 20'h00123;
    core_mem_r_value    = 16'h5A5A;
    core_wait           = 1'b1;
    i_req               = 3'b001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("ws_req",   32'(core_mem_request), 32'h1);
      check("ws_addr",  32'(core_mem_addr), 32'h00123);
      check("ws_wr",    32'(core_mem_wr), 32'h0);
      check("ws_noack", 32'(o_ack), 32'h0);
      if (c == 2) i_req = 3'b011;
      if (c == 6) core_wait = 1'b0;
    end
    tick();
    check("ws_ack",   32'(o_ack), 32'b001);
    check("ws_rdata", 32'(o_rdata), 32'h5A5A);
    check("ws_reqlo", 32'(core_mem_request), 32'h0);
    i_req = 3'b010;
    tick();
    check("ws_idle",  32'(o_busy), 32'h0);
    tick();
    check("ws_next_grant", 32'(o_grant_id), 32'h1);
    check("ws_next_addr",  32'(core_mem_addr), 32'h00400);
    i_req = 3'b000;
    tick();
    check("ws_next_ack",   32'(o_ack), 32'b010);
    tick();
    $display("txn wait-state read req0 then req1 served");

    // ---- timeout on requester 2; requester 0 waits behind it ----
    core_wait        = 1'b1;
    core_mem_r_value = 16'h7777;
    i_req            = 3'b101;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      tick();
      check("to_req",   32'(core_mem_request), 32'h1);
      check("to_grant", 32'(o_grant_id), 32'h2);
      check("to_noack", 32'(o_ack), 32'h0);
    end
    tick();
    check("to_reqlo", 32'(core_mem_request), 32'h0);
    check("to_ack",   32'(o_ack), 32'b100);
    check("to_err",   32'(o_err), 32'h1);
    check("to_rdata", 32'(o_rdata), 32'h0);
    i_req     = 3'b001;
    core_wait = 1'b0;
    tick();
    check("to_idle",  32'(o_busy), 32'h0);
    tick();
    check("to_next_grant", 32'(o_grant_id), 32'h0);
    check("to_next_req",   32'(core_mem_request), 32'h1);
    i_req = 3'b000;
    tick();
    check("to_next_ack",   32'(o_ack), 32'b001);
    check("to_next_err",   32'(o_err), 32'h0);
    check("to_next_rdata", 32'(o_rdata), 32'h7777);
    tick();
    $display("txn timeout req2 err=1, req0 served after");

    // ---- reset asserted mid-wait ----
    core_wait = 1'b1;
    i_req     = 3'b010;
    tick();
    check("rb_req",   32'(core_mem_request), 32'h1);
    check("rb_grant", 32'(o_grant_id), 32'h1);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rb_reqlo", 32'(core_mem_request), 32'h0);
    check("rb_ack",   32'(o_ack), 32'h0);
    check("rb_busy",  32'(o_busy), 32'h0);
    tick();
    check("rb_ack_r", 32'(o_ack), 32'h0);
    i_req     = 3'b011;
    core_wait = 1'b0;
    i_rst_n   = 1'b1;
    tick();
    check("rb_first_grant", 32'(o_grant_id), 32'h0);
    check("rb_first_req",   32'(core_mem_request), 32'h1);
    check("rb_first_addr",  32'(core_mem_addr), 32'h00123);
    i_req = 3'b010;
    tick();
    check("rb_first_ack",   32'(o_ack), 32'b001);
    $display("txn reset mid-access: request dropped, req0 first after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
# sram_access_arbiter

Shares the single SRAM controller command port (core_mem_* / core_wait) among the gesture pipeline's memory clients: library recording, resampling, and library fetch for similarity scoring. It picks one pending client by round-robin and latches its command. It holds the command stable across controller wait states and returns the read data with a one-cycle acknowledge. It sits between the recognition top-level's requesters and the SRAM controller, replacing per-state address muxing.

## Interface
- N_REQ, 3: number of requesters (2..8).
- ADDR_W, 20: SRAM word address width.
- DATA_W, 16: SRAM data width.
- TIMEOUT, 255: maximum wait-state cycles per access before abort (≥1).

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  N_REQ  per-requester access request.
  - Level signal.
  - Hold high with the command stable until the matching o_ack bit pulses.
- i_wr  in  N_REQ  1 = write, 0 = read, per requester.
- i_addr  in  N_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- i_wdata  in  N_REQ*DATA_W  packed write data, same packing as i_addr.
- o_ack  out  N_REQ  one-cycle completion pulse; at most one bit high.
- o_err  out  1  high with o_ack when the access was aborted by timeout.
- o_rdata  out  DATA_W  read data; valid only in the o_ack cycle.
- o_busy  out  1  high when state ≠ IDLE.
- o_grant_id  out  clog2(N_REQ)  index of the current/last granted requester.
- core_mem_request  out  1  command valid to the SRAM controller.
- core_mem_wr  out  1  write enable to the controller.
- core_mem_addr  out  ADDR_W  address to the controller.
- core_mem_w_value  out  DATA_W  write data to the controller.
- core_mem_r_value  in  DATA_W  read data from the controller.
- core_wait  in  1  controller stall.
  - An access completes in any cycle with core_mem_request=1 and core_wait=0.
  - Read data is valid in that same cycle.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any i_req bit is set, grant the first set bit at or after (last_grant+1) mod N_REQ.
  - Latch that requester's wr/addr/wdata, set last_grant and o_grant_id, go to BUSY.
  - If no request is set, stay in IDLE.
- BUSY:
  - core_mem_request=1; core_mem_wr/addr/w_value come from the latched registers and stay stable for the whole state.
  - If core_wait=0: capture core_mem_r_value into o_rdata (capture 0 for writes), go to DONE.
  - If core_wait=1 and the wait counter = TIMEOUT: deassert the request, set o_rdata=0, flag the error, go to DONE.
  - Otherwise (core_wait=1 and wait counter < TIMEOUT): increment the wait counter.
  - The wait counter is clog2(TIMEOUT+1) bits and clears on every entry to BUSY.
- DONE:
  - o_ack[last_grant]=1; o_err reflects the timeout flag; no arbitration occurs.
  - Always go to IDLE. This gives the requester one cycle to present its next command or drop i_req.
- Outside BUSY: core_mem_request=0. core_mem_addr/w_value/wr hold their latched values; they are not zeroed.
- If a requester drops i_req while granted, the access still completes and o_ack still pulses.
- Non-granted i_req changes have no effect until the next IDLE.
- Reset values:
  - state IDLE; last_grant = N_REQ-1, so requester 0 wins first.
  - All outputs 0: o_ack, o_err, o_rdata, o_busy, o_grant_id, core_mem_request, core_mem_wr, core_mem_addr, core_mem_w_value.
  - Wait counter 0.
- Reset asserted mid-access:
  - core_mem_request drops asynchronously and no o_ack is issued.
  - The aborted requester must re-request.

## Timing
- Request seen in IDLE at cycle t → core_mem_request high from t+1.
- With zero wait states, completion is at t+1, o_ack/o_rdata at t+2, IDLE at t+3.
- Minimum 3 cycles per access; each wait cycle adds 1.
- Timeout: request high for exactly TIMEOUT+1 cycles, then o_ack+o_err on the next cycle.
- All outputs are registered; there is no combinational path from i_req or core_wait to any output.
- Round-robin is fair: with all N_REQ requests held high, each requester is granted once per N_REQ accesses.

## Test plan
- Single read:
  - Stimulus: i_req=3'b010, addr1=20'h00400, core_wait=0, core_mem_r_value=16'h1234.
  - Required: core_mem_request high 1 cycle with addr 20'h00400, wr=0; o_ack=3'b010, o_rdata=16'h1234 two cycles after the request.
- Write:
  - Stimulus: requester 2, wr=1, addr=20'h06800, wdata=16'hBEEF.
  - Required: core_mem_wr=1, core_mem_w_value=16'hBEEF during BUSY; o_ack=3'b100, o_err=0.
- Fairness:
  - Stimulus: all three requests held high from reset for 6 accesses.
  - Required: grant order 0,1,2,0,1,2; o_ack spacing 3 cycles.
- Wait states:
  - Stimulus: core_wait high for 5 BUSY cycles.
  - Required: core_mem_request high 6 cycles with addr/wr/w_value unchanged; o_ack the cycle after core_wait falls.
- Timeout:
  - Stimulus: TIMEOUT=8, core_wait stuck high.
  - Required: request high 9 cycles, then o_ack with o_err=1, o_rdata=0; the next requester is served normally afterwards.
- Reset in BUSY:
  - Stimulus: assert i_rst_n=0 mid-wait.
  - Required: core_mem_request=0 immediately, no o_ack; after release, requester 0 is granted first.
